// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: stall vector layout,
// bus widths and the default boot address.
package if_stage_pkg;

    // Stall vector width; bit 0 belongs to the PC.
    localparam int STALL_W = 6;

    // Encoding of a stall bit.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // {ce, pc} handed to decode.
    localparam int IF_TO_ID_WD = 33;

    // {br_e, br_addr} handed back from decode.
    localparam int BR_WD = 33;

    // Boot vector: first instruction fetched after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/if_stage_pc_redirect.sv
// Next-PC selection plus a latch that remembers a branch target arriving
// while the PC is frozen, so the redirect is applied once the stall lifts.
module if_stage_pc_redirect
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    logic        br_pend;
    logic [31:0] br_pend_addr;

    // Live branch beats a pending one; otherwise fall through sequentially.
    always_comb begin
        next_pc = pc + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend) begin
            next_pc = br_pend_addr;
        end
    end

    // Capture redirects during a stall; the newest target wins, and any
    // pending target is consumed on the first unstalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_pend      <= 1'b0;
            br_pend_addr <= 32'd0;
        end else if (stop == NO_STOP) begin
            br_pend      <= 1'b0;
        end else if (br_e) begin
            br_pend      <= 1'b1;
            br_pend_addr <= br_addr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// SRAM read port and passes {ce, pc} to decode. Outputs depend only on
// registers, so there is no combinational path from br_bus or stall.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic                   if_adel
);

    logic        br_e;
    logic [31:0] br_addr;
    logic        stop;
    logic [31:0] next_pc;
    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        stall_unused;

    assign {br_e, br_addr} = br_bus;
    assign stop            = stall[0];
    assign stall_unused    = ^stall[STALL_W-1:1];

    if_stage_pc_redirect u_pc_redirect (
        .clk     (clk),
        .rst     (rst),
        .stop    (stop),
        .br_e    (br_e),
        .br_addr (br_addr),
        .pc      (pc_reg),
        .next_pc (next_pc)
    );

    // PC sits one word before the boot vector in reset so the first
    // unstalled cycle fetches RESET_PC; a stall freezes both PC and ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC - 32'd4;
            ce_reg <= 1'b0;
        end else if (stop == NO_STOP) begin
            pc_reg <= next_pc;
            ce_reg <= 1'b1;
        end
    end

    // SRAM port and decode bus come straight from the registers.
    always_comb begin
        inst_sram_en    = ce_reg;
        inst_sram_wen   = 4'b0000;
        inst_sram_addr  = pc_reg;
        inst_sram_wdata = 32'd0;
        if_to_id_bus    = {ce_reg, pc_reg};
        if_adel         = ce_reg & (pc_reg[1:0] != 2'b00);
    end

endmodule
